fifo_write_arbiter: RTL and testbench

//  Round-robin arbiter that shares the write port of asynchronous_fifo among
//  NUM_REQ requesters in the write-clock domain. Grants one requester at a

---
 rtl/fifo_write_arbiter_if.sv | 24 ++
 rtl/fifo_write_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side and FIFO-side write bus shared by fifo_write_arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the FIFO.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_w_en;
  logic [DATA_WIDTH-1:0]         fifo_data;

  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_w_en, fifo_data
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_w_en, fifo_data
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Bounded bursts, one idle arbitration cycle per burst, combinational full backpressure.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                       i_wclk,
  input  logic                       i_wrst,
  fifo_write_arbiter_if.master       bus,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic                       o_burst_done
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]            r_state;
  logic [GW-1:0]         r_rr_ptr;
  logic [GW-1:0]         r_grant_id;
  logic [BW-1:0]         r_beat_cnt;

  logic                  w_in_burst;
  logic                  w_any_valid;
  logic [GW-1:0]         w_pick;
  int                    w_j;
  logic                  w_g_valid;
  logic                  w_g_last;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic                  w_accept;
  logic                  w_end;
  logic [GW-1:0]         w_next_ptr;

  assign w_in_burst  = (r_state == ST_BURST);
  assign w_any_valid = |bus.req_valid;

  // Scan from the highest rotation offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_pick = '0;
    w_j    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = int'(r_rr_ptr) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (bus.req_valid[w_j]) w_pick = GW'(w_j);
    end
  end

  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GW'(i)) begin
        w_g_valid = bus.req_valid[i];
        w_g_last  = bus.req_last[i];
        w_g_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Full gates the write with no register in the path, so a write never lands on full.
  assign w_accept = w_in_burst & w_g_valid & ~bus.fifo_full;

  assign w_end = w_in_burst &
                 (~w_g_valid |
                  (w_accept & (w_g_last | (r_beat_cnt == BW'(MAX_BURST - 1)))));

  assign w_next_ptr = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + GW'(1);

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = w_accept & (r_grant_id == GW'(i));
    end
  end

  assign bus.fifo_w_en = w_accept;
  assign bus.fifo_data = w_g_data;

  assign o_grant_id   = r_grant_id;
  assign o_busy       = w_in_burst;
  assign o_burst_done = w_end;

  always_ff @(posedge i_wclk or negedge i_wrst) begin
    if (!i_wrst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any_valid) begin
        r_grant_id <= w_pick;
        r_beat_cnt <= '0;
        r_state    <= ST_BURST;
      end
    end else begin
      if (w_end) begin
        r_state    <= ST_IDLE;
        r_rr_ptr   <= w_next_ptr;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, single burst, fairness,
// backpressure, withdraw, and a multi-requester ordering run with random full.
module tb_fifo_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic       wclk = 1'b0;
  logic       wrst = 1'b0;
  logic [1:0] grant_id;
  logic       busy;
  logic       burst_done;

  fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_wclk       (wclk),
    .i_wrst       (wrst),
    .bus          (bus),
    .o_grant_id   (grant_id),
    .o_busy       (busy),
    .o_burst_done (burst_done)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst          = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    repeat (2) @(negedge wclk);
    wrst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt [NR];
    int rcv [NR];
    int idx;
    int seq;
    int cyc;
    int total;

    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;

    // T1: reset state, then async reset in the middle of a granted burst
    #2;
    check("t1_rst_busy", busy, 0);
    check("t1_rst_wen", bus.fifo_w_en, 0);
    check("t1_rst_ready", bus.req_ready, 0);
    check("t1_rst_grant", grant_id, 0);
    check("t1_rst_done", burst_done, 0);
    @(negedge wclk);
    wrst = 1'b1;
    bus.req_valid = 4'b0001;
    set_data(0, 8'h11);
    #1;
    check("t1_gap_busy", busy, 0);
    @(negedge wclk); #1;
    check("t1_burst_wen", bus.fifo_w_en, 1);
    check("t1_burst_data", bus.fifo_data, 8'h11);
    #2 wrst = 1'b0;
    #1;
    check("t1_mid_wen", bus.fifo_w_en, 0);
    check("t1_mid_ready", bus.req_ready, 0);
    check("t1_mid_busy", busy, 0);
    check("t1_mid_grant", grant_id, 0);
    @(negedge wclk);
    wrst = 1'b1;
    @(negedge wclk); #1;
    check("t1_regrant_busy", busy, 1);
    check("t1_regrant_id", grant_id, 0);
    check("t1_regrant_ready", bus.req_ready, 4'b0001);

    // T2: req1 sends three words with last on the third
    do_reset();
    bus.req_valid = 4'b0010;
    set_data(1, 8'hA1);
    #1;
    check("t2_gap_wen", bus.fifo_w_en, 0);
    @(negedge wclk); #1;
    check("t2_grant", grant_id, 1);
    check("t2_a1_wen", bus.fifo_w_en, 1);
    check("t2_a1_data", bus.fifo_data, 8'hA1);
    check("t2_a1_ready", bus.req_ready, 4'b0010);
    check("t2_a1_done", burst_done, 0);
    @(negedge wclk);
    set_data(1, 8'hA2);
    #1;
    check("t2_a2_data", bus.fifo_data, 8'hA2);
    check("t2_a2_done", burst_done, 0);
    @(negedge wclk);
    set_data(1, 8'hA3);
    bus.req_last = 4'b0010;
    #1;
    check("t2_a3_wen", bus.fifo_w_en, 1);
    check("t2_a3_data", bus.fifo_data, 8'hA3);
    check("t2_a3_done", burst_done, 1);
    @(negedge wclk);
    bus.req_valid = '0;
    bus.req_last  = '0;
    #1;
    check("t2_after_busy", busy, 0);
    check("t2_after_done", burst_done, 0);
    check("t2_hold_grant", grant_id, 1);
    @(negedge wclk);
    bus.req_valid = 4'b1111;
    @(negedge wclk); #1;
    check("t2_rrptr_next", grant_id, 2);

    // T3: all requesters valid, no last: 4-beat bursts, order 0,1,2,3,0
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) set_data(i, 8'(8'h30 + i));
    for (int k = 0; k < 25; k++) begin
      int owner;
      if (k > 0) @(negedge wclk);
      #1;
      owner = (k / 5) % NR;
      if (k % 5 == 0) begin
        check($sformatf("t3_gap_ready_%0d", k), bus.req_ready, 0);
        check($sformatf("t3_gap_wen_%0d", k), bus.fifo_w_en, 0);
      end else begin
        check($sformatf("t3_ready_%0d", k), bus.req_ready, 32'(1 << owner));
        check($sformatf("t3_data_%0d", k), bus.fifo_data, 32'(8'h30 + owner));
      end
      check($sformatf("t3_done_%0d", k), burst_done, (k % 5 == 4) ? 1 : 0);
    end

    // T4: full for 5 cycles after 2 beats of req2
    do_reset();
    bus.req_valid = 4'b0100;
    set_data(2, 8'hC0);
    #1;
    check("t4_gap_wen", bus.fifo_w_en, 0);
    @(negedge wclk); #1;
    check("t4_b0_data", bus.fifo_data, 8'hC0);
    @(negedge wclk);
    set_data(2, 8'hC1);
    #1;
    check("t4_b1_wen", bus.fifo_w_en, 1);
    check("t4_b1_data", bus.fifo_data, 8'hC1);
    for (int k = 0; k < 5; k++) begin
      @(negedge wclk);
      set_data(2, 8'hC2);
      bus.fifo_full = 1'b1;
      #1;
      check($sformatf("t4_full_wen_%0d", k), bus.fifo_w_en, 0);
      check($sformatf("t4_full_ready_%0d", k), bus.req_ready, 0);
      check($sformatf("t4_full_busy_%0d", k), busy, 1);
      check($sformatf("t4_full_grant_%0d", k), grant_id, 2);
      check($sformatf("t4_full_done_%0d", k), burst_done, 0);
    end
    @(negedge wclk);
    bus.fifo_full = 1'b0;
    #1;
    check("t4_b2_data", bus.fifo_data, 8'hC2);
    check("t4_b2_done", burst_done, 0);
    @(negedge wclk);
    set_data(2, 8'hC3);
    #1;
    check("t4_b3_wen", bus.fifo_w_en, 1);
    check("t4_b3_done", burst_done, 1);
    @(negedge wclk); #1;
    check("t4_release_busy", busy, 0);

    // T5: req3 withdraws after one beat, pointer wraps to 0
    do_reset();
    bus.req_valid = 4'b1000;
    set_data(3, 8'hD0);
    @(negedge wclk); #1;
    check("t5_grant", grant_id, 3);
    check("t5_beat_wen", bus.fifo_w_en, 1);
    @(negedge wclk);
    bus.req_valid = 4'b0000;
    #1;
    check("t5_wd_done", burst_done, 1);
    check("t5_wd_wen", bus.fifo_w_en, 0);
    @(negedge wclk);
    bus.req_valid = 4'b1010;
    set_data(1, 8'hE1);
    #1;
    check("t5_idle_busy", busy, 0);
    check("t5_idle_done", burst_done, 0);
    @(negedge wclk); #1;
    check("t5_next_grant", grant_id, 1);
    check("t5_next_ready", bus.req_ready, 4'b0010);
    check("t5_next_data", bus.fifo_data, 8'hE1);

    // T6: 20 tagged words per requester under random full; order and count
    do_reset();
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      rcv[i] = 0;
    end
    total = 0;
    cyc   = 0;
    while (total < NR * 20 && cyc < 3000) begin
      if (cyc > 0) @(negedge wclk);
      for (int i = 0; i < NR; i++) begin
        bus.req_valid[i] = (cnt[i] < 20);
        bus.req_last[i]  = (cnt[i] % 3 == 2);
        set_data(i, 8'((i << 6) | cnt[i]));
      end
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      if (bus.fifo_w_en) begin
        idx = int'(bus.fifo_data[7:6]);
        seq = int'(bus.fifo_data[5:0]);
        check("t6_nofull", bus.fifo_full, 0);
        check("t6_ready", bus.req_ready, 32'(1 << idx));
        check($sformatf("t6_order_r%0d", idx), seq, rcv[idx]);
        rcv[idx]++;
        total++;
      end
      for (int i = 0; i < NR; i++) if (bus.req_ready[i]) cnt[i]++;
      cyc++;
    end
    check("t6_timeout", (total == NR * 20) ? 1 : 0, 1);
    for (int i = 0; i < NR; i++) check($sformatf("t6_count_r%0d", i), rcv[i], 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
